noc_output_port: RTL and testbench
==================================

Name: noc_output_port

Overview:
- Transmit side of the router-to-router flit link.
- Drains the router's flit FIFO and makes an XY routing decision on each head flit.
- Locks the chosen output direction (L/N/E/S/W) for the whole packet.
- Delivers each flit to the downstream input port using the 4-phase req/ack handshake that input ports already implement; one instance per router.

Parameters:
- DATA_WIDTH, 37: flit width. Bit 4 = tail flag; bits [3:0] = destination {X[3:2],Y[1:0]}.
- POSITION, 4'b0101: this router's coordinate {X[3:2],Y[1:0]}.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- fifo_q  in  DATA_WIDTH  FIFO read data, valid the cycle after rdreq.
- fifo_empty  in  1  FIFO empty flag.
- rdreq  out  1  FIFO read strobe, one-cycle pulse.
- dataOut  out  DATA_WIDTH  flit bus, shared by all five directions.
- Outr_L, Outr_N, Outr_E, Outr_S, Outr_W  out  1 each  per-direction request (drives neighbour's Inr_*).
- Outw_L, Outw_N, Outw_E, Outw_S, Outw_W  in  1 each  per-direction acknowledge (neighbour's Inw_*).
- busy  out  1  high from a head flit's fetch until its tail flit's ack falls.
- pkt_sent  out  1  one-cycle pulse when a tail flit completes.

Behaviour:
- Reset (async) clears: rdreq=0, dataOut=0, all Outr_*=0, busy=0, pkt_sent=0, state=IDLE, head_flag=1, dir=L. Reset mid-handshake drops req immediately; the partially sent packet is abandoned.
- Direction encoding (matches input-port index): W=0, S=1, E=2, N=3, L=4. Exactly one Outr_* may be high at any time.
- XY route, evaluated only on a head flit (head_flag=1), using unsigned 2-bit compares:
  - dX>myX -> E; dX<myX -> W.
  - else dY>myY -> N; dY<myY -> S.
  - else L.
- Body and tail flits reuse the latched dir.
- FSM states:
  - IDLE: if !fifo_empty, pulse rdreq=1, go FETCH; else stay.
  - FETCH: capture fifo_q into dataOut. If head_flag, compute and latch dir, set busy=1. Go REQ.
  - REQ: Outr[dir]=1. When Outw[dir]=1, drop Outr[dir] on the next edge and go REL.
  - REL: wait for Outw[dir]=0. Then:
    - if dataOut[4]=1: head_flag=1, busy=0, pulse pkt_sent, go IDLE.
    - else: head_flag=0, go IDLE.
- Handshake rules:
  - dataOut is stable from FETCH exit until REL exit.
  - Req never rises while ack[dir] is still high; REL guarantees this.
  - Acks on non-selected directions are ignored.
  - Ack already high on entering REQ is accepted (req/ack overlap is one cycle minimum).
- Latency:
  - fifo_empty falling to Outr rising: 2 cycles (IDLE->FETCH->REQ).
  - Minimum per-flit period with an immediate responder: 5 cycles.
- Empty mid-packet: stay in IDLE with dir and head_flag held; no req asserted; resume when data arrives.
- Back-pressure: REQ waits indefinitely. There is no timeout; deadlock avoidance relies on XY ordering.
- A single-flit packet (head with tail=1) routes and releases in the same packet.
- Destination equal to POSITION routes to L.

Test Plan:
- POSITION=0101, single flit {tail=1, dest=1101} -> Outr_E=1 only, 2 cycles after empty falls; neighbour acks -> Outr_E drops; ack falls -> pkt_sent pulse, busy=0.
- 3-flit packet, head dest=0100 then body and tail with bits[3:0]=0000 -> all three on Outr_S (dir locked); busy high throughout; one pkt_sent pulse after the third ack falls.
- dest=0101 -> Outr_L; dest=0001 -> Outr_W; dest=0111 -> Outr_N; verify exactly one Outr_* per flit.
- Back-pressure: hold Outw_E=0 for 50 cycles -> Outr_E stays 1, dataOut constant, rdreq stays 0; release -> normal completion.
- Spurious Outw_N=1 while sending on E -> ignored, no state change. FIFO empties between body flits -> Outr stays low, dir retained; next flit goes to the same port.
- Assert reset while Outr_E=1 -> Outr_E=0 and dataOut=0 immediately; next flit after reset is treated as a head and rerouted.

Source files
------------

// File: rtl/noc_output_port.sv
// ============================================================================
// noc_output_port : flit-FIFO drain, XY route on head flit, 4-phase req/ack TX
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_output_port #(
  parameter int         DATA_WIDTH = 37,
  parameter logic [3:0] POSITION   = 4'b0101
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  input  logic                  fifo_empty,
  output logic                  rdreq,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  Outr_L,
  output logic                  Outr_N,
  output logic                  Outr_E,
  output logic                  Outr_S,
  output logic                  Outr_W,
  input  logic                  Outw_L,
  input  logic                  Outw_N,
  input  logic                  Outw_E,
  input  logic                  Outw_S,
  input  logic                  Outw_W,
  output logic                  busy,
  output logic                  pkt_sent
);

  localparam logic [2:0] c_DIR_W = 3'd0;
  localparam logic [2:0] c_DIR_S = 3'd1;
  localparam logic [2:0] c_DIR_E = 3'd2;
  localparam logic [2:0] c_DIR_N = 3'd3;
  localparam logic [2:0] c_DIR_L = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_REQ   = 2'd2,
    S_REL   = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_rdreq;
  logic [DATA_WIDTH-1:0] r_data;
  logic [4:0]            r_outr;
  logic [2:0]            r_dir;
  logic                  r_head;
  logic                  r_busy;
  logic                  r_pkt_sent;

  logic [4:0]            w_ack;
  logic                  w_ack_sel;
  logic [2:0]            w_route;
  logic [2:0]            w_dir_next;
  logic [4:0]            w_onehot;

  // Vector bit index equals the direction code, so ack/req select by r_dir.
  assign w_ack     = {Outw_L, Outw_N, Outw_E, Outw_S, Outw_W};
  assign w_ack_sel = w_ack[r_dir];

  always_comb begin
    w_route = c_DIR_L;
    if (fifo_q[3:2] > POSITION[3:2])      w_route = c_DIR_E;
    else if (fifo_q[3:2] < POSITION[3:2]) w_route = c_DIR_W;
    else if (fifo_q[1:0] > POSITION[1:0]) w_route = c_DIR_N;
    else if (fifo_q[1:0] < POSITION[1:0]) w_route = c_DIR_S;
  end

  assign w_dir_next = r_head ? w_route : r_dir;
  assign w_onehot   = 5'b00001 << w_dir_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rdreq    <= 1'b0;
      r_data     <= '0;
      r_outr     <= '0;
      r_dir      <= c_DIR_L;
      r_head     <= 1'b1;
      r_busy     <= 1'b0;
      r_pkt_sent <= 1'b0;
    end else begin
      r_rdreq    <= 1'b0;
      r_pkt_sent <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!fifo_empty) begin
            r_rdreq <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_data  <= fifo_q;
          r_dir   <= w_dir_next;
          r_outr  <= w_onehot;
          if (r_head) r_busy <= 1'b1;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (w_ack_sel) begin
            r_outr  <= '0;
            r_state <= S_REL;
          end
        end
        S_REL: begin
          // Waiting for ack low here keeps the next req from overlapping it.
          if (!w_ack_sel) begin
            if (r_data[4]) begin
              r_head     <= 1'b1;
              r_busy     <= 1'b0;
              r_pkt_sent <= 1'b1;
            end else begin
              r_head <= 1'b0;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rdreq    = r_rdreq;
  assign dataOut  = r_data;
  assign Outr_W   = r_outr[0];
  assign Outr_S   = r_outr[1];
  assign Outr_E   = r_outr[2];
  assign Outr_N   = r_outr[3];
  assign Outr_L   = r_outr[4];
  assign busy     = r_busy;
  assign pkt_sent = r_pkt_sent;

endmodule

`default_nettype wire

// File: tb/tb_noc_output_port.sv
// ============================================================================
// tb_noc_output_port : directed bench for noc_output_port (POSITION = 0101)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_output_port;

  logic        clk;
  logic        reset;
  logic [36:0] fifo_q;
  logic        fifo_empty;
  logic        rdreq;
  logic [36:0] dataOut;
  logic        Outr_L, Outr_N, Outr_E, Outr_S, Outr_W;
  logic [4:0]  ack;
  logic        busy;
  logic        pkt_sent;
  logic [4:0]  outr;

  int n_cmp = 0;
  int n_err = 0;

  noc_output_port #(
    .DATA_WIDTH (37),
    .POSITION   (4'b0101)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_q     (fifo_q),
    .fifo_empty (fifo_empty),
    .rdreq      (rdreq),
    .dataOut    (dataOut),
    .Outr_L     (Outr_L),
    .Outr_N     (Outr_N),
    .Outr_E     (Outr_E),
    .Outr_S     (Outr_S),
    .Outr_W     (Outr_W),
    .Outw_L     (ack[4]),
    .Outw_N     (ack[3]),
    .Outw_E     (ack[2]),
    .Outw_S     (ack[1]),
    .Outw_W     (ack[0]),
    .busy       (busy),
    .pkt_sent   (pkt_sent)
  );

  assign outr = {Outr_L, Outr_N, Outr_E, Outr_S, Outr_W};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one flit; req must appear on the expected port two edges later.
  task automatic fetch_flit(input logic [36:0] f, input int d);
    logic [4:0] e;
    e = 5'b00001 << d;
    fifo_q     = f;
    fifo_empty = 1'b0;
    @(negedge clk);
    chk("rdreq_pulse", {63'd0, rdreq}, 64'd1);
    chk("req_early", {59'd0, outr}, 64'd0);
    fifo_empty = 1'b1;
    @(negedge clk);
    chk("req_dir", {59'd0, outr}, {59'd0, e});
    chk("dataOut", {27'd0, dataOut}, {27'd0, f});
    chk("rdreq_low", {63'd0, rdreq}, 64'd0);
    chk("busy_fetch", {63'd0, busy}, 64'd1);
  endtask

  // Neighbour acks for one cycle, then drops ack.
  task automatic ack_flit(input int d, input logic tail);
    ack[d] = 1'b1;
    @(negedge clk);
    chk("req_drop", {59'd0, outr}, 64'd0);
    chk("pkt_early", {63'd0, pkt_sent}, 64'd0);
    ack[d] = 1'b0;
    @(negedge clk);
    chk("pkt_sent", {63'd0, pkt_sent}, {63'd0, tail});
    chk("busy_after", {63'd0, busy}, {63'd0, ~tail});
    @(negedge clk);
    chk("pkt_pulse", {63'd0, pkt_sent}, 64'd0);
  endtask

  initial begin
    int bad;
    logic [36:0] f;
    reset      = 1'b1;
    fifo_empty = 1'b1;
    fifo_q     = '0;
    ack        = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdreq", {63'd0, rdreq}, 64'd0);
    chk("rst_data", {27'd0, dataOut}, 64'd0);
    chk("rst_outr", {59'd0, outr}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_pkt", {63'd0, pkt_sent}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single-flit packet to 1101 -> East
    fetch_flit({32'h1111_0001, 1'b1, 4'hD}, 2);
    ack_flit(2, 1'b1);

    // Three-flit packet, head 0100 -> South; body/tail dest 0000 stay on South
    fetch_flit({32'h2222_0001, 1'b0, 4'h4}, 1);
    ack_flit(1, 1'b0);
    fetch_flit({32'h2222_0002, 1'b0, 4'h0}, 1);
    ack_flit(1, 1'b0);
    fetch_flit({32'h2222_0003, 1'b1, 4'h0}, 1);
    ack_flit(1, 1'b1);

    // Local, West, North single flits
    fetch_flit({32'h3333_0001, 1'b1, 4'h5}, 4);
    ack_flit(4, 1'b1);
    fetch_flit({32'h3333_0002, 1'b1, 4'h1}, 0);
    ack_flit(0, 1'b1);
    fetch_flit({32'h3333_0003, 1'b1, 4'h7}, 3);
    ack_flit(3, 1'b1);

    // Back-pressure: 50 cycles without ack on East
    f = {32'h4444_0001, 1'b1, 4'hE};
    fetch_flit(f, 2);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (outr !== 5'b00100 || dataOut !== f || rdreq !== 1'b0) bad++;
    end
    chk("bp_hold", bad, 0);
    ack_flit(2, 1'b1);

    // Spurious North ack while sending East, then FIFO empty mid-packet
    fetch_flit({32'h5555_0001, 1'b0, 4'hF}, 2);
    ack[3] = 1'b1;
    repeat (3) @(negedge clk);
    chk("spurious_outr", {59'd0, outr}, 64'h4);
    ack[3] = 1'b0;
    ack_flit(2, 1'b0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (outr !== 5'b00000 || rdreq !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("empty_hold", bad, 0);
    fetch_flit({32'h5555_0002, 1'b1, 4'h0}, 2);
    ack_flit(2, 1'b1);

    // Reset while req East is high; next flit is a fresh head
    fetch_flit({32'h6666_0001, 1'b0, 4'hD}, 2);
    #2 reset = 1'b1;
    #1;
    chk("arst_outr", {59'd0, outr}, 64'd0);
    chk("arst_data", {27'd0, dataOut}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    fetch_flit({32'h6666_0002, 1'b1, 4'h7}, 3);
    ack_flit(3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
